// File: rtl/i2c_cfg_arb_pkg.sv
// Shared types and defaults for the i2c_cfg_arb register-init arbiter.
package i2c_cfg_pkg;

  localparam int ADDR_W_DEF = 16;      // register address width (two address bytes)
  localparam int DEV_W      = 8;       // 7-bit device address plus R/W bit
  localparam int TO_CYC_DEF = 200000;  // 20 ms at 10 MHz

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/i2c_cfg_arb_if.sv
// Engine-side bundle between i2c_cfg_arb (master) and the i2c_dri engine (slave).
interface i2c_cfg_arb_if
  import i2c_cfg_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              pluse;
  logic              w_r;
  logic [DEV_W-1:0]  dev_id;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic              busy;
  logic              byte_over;
  logic [7:0]        rdata;

  modport master (
    output pluse, w_r, dev_id, addr, wdata,
    input  busy, byte_over, rdata
  );

  modport slave (
    input  pluse, w_r, dev_id, addr, wdata,
    output busy, byte_over, rdata
  );

endinterface

// File: rtl/i2c_cfg_arb_rr_arbiter.sv
// Combinational round-robin selector: the search starts one channel past the
// previous owner; an all-zero last grant (after reset) starts at channel 0.
module rr_arbiter #(
  parameter int N_CH = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [N_CH-1:0] last,
  output logic [N_CH-1:0] grant
);

  int   start_idx;
  logic found;

  // Turn the one-hot last grant into the first channel to consider.
  always_comb begin
    start_idx = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (last[i]) start_idx = (i == N_CH - 1) ? 0 : i + 1;
    end
  end

  // Walk channels in priority order and take the first requester.
  // NOTE: every output of a combinational block gets a default before any
  // condition, otherwise an unassigned path infers a latch.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      for (int i = 0; i < N_CH; i++) begin
        if (!found && req[i] && (i == ((start_idx + k) % N_CH))) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/i2c_cfg_arb.sv
// i2c_cfg_arb: shares one i2c_dri engine between N_CH register-init requesters.
// Each trigger latches its channel's fields into a pending slot; a
// round-robin FSM issues one transaction at a time to the engine.
// Optional feature: define I2C_CFG_ARB_TIMEOUT_EN to add a TO_CYC-cycle
// transaction timeout that pulses req_err and frees the channel.
module i2c_cfg_arb
  import i2c_cfg_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int TO_CYC = TO_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        req_trig,
  input  logic [N_CH-1:0]        req_w_r,
  input  logic [DEV_W*N_CH-1:0]  req_dev_id,
  input  logic [ADDR_W*N_CH-1:0] req_addr,
  input  logic [8*N_CH-1:0]      req_wdata,
  output logic [N_CH-1:0]        req_busy,
  output logic [N_CH-1:0]        req_byte_over,
  output logic [7:0]             req_rdata,
  output logic [N_CH-1:0]        req_err,
  output logic [N_CH-1:0]        grant_oh,
  output logic                   drv_pluse,
  output logic                   drv_w_r,
  output logic [DEV_W-1:0]       drv_dev_id,
  output logic [ADDR_W-1:0]      drv_addr,
  output logic [7:0]             drv_wdata,
  input  logic                   drv_busy,
  input  logic                   drv_byte_over,
  input  logic [7:0]             drv_rdata
);

  if (N_CH < 1 || N_CH > 8) begin : g_bad_n_ch
    $error("i2c_cfg_arb: N_CH must be in 1..8");
  end
  if (TO_CYC < 1) begin : g_bad_to_cyc
    $error("i2c_cfg_arb: TO_CYC must be at least 1");
  end

  state_t            state, state_nxt;
  logic [N_CH-1:0]   pending;
  logic [N_CH-1:0]   arb_grant;
  logic [N_CH-1:0]   rel_mask;
  logic              do_grant, do_issue, do_done, do_byte, do_timeout;
  logic              to_hit;

  logic              cap_w_r   [N_CH];
  logic [DEV_W-1:0]  cap_dev   [N_CH];
  logic [ADDR_W-1:0] cap_addr  [N_CH];
  logic [7:0]        cap_wdata [N_CH];

  logic              sel_w_r;
  logic [DEV_W-1:0]  sel_dev;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_wdata;

  rr_arbiter #(.N_CH(N_CH)) u_rr (
    .req   (pending),
    .last  (grant_oh),
    .grant (arb_grant)
  );

  // FSM state register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking (=) belongs only in combinational blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nxt  = state;
    do_grant   = 1'b0;
    do_issue   = 1'b0;
    do_done    = 1'b0;
    do_byte    = 1'b0;
    do_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (|pending) begin
          do_grant  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        do_issue  = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (to_hit) begin
          do_timeout = 1'b1;
          state_nxt  = IDLE;
        end else if (drv_busy) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        do_byte = drv_byte_over;
        if (!drv_busy) begin
          do_done   = 1'b1;
          state_nxt = IDLE;
        end else if (to_hit) begin
          do_timeout = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rel_mask = (do_done || do_timeout) ? grant_oh : '0;
  assign req_busy = pending;

  // Latch a channel's fields when it triggers from the not-pending state.
  // NOTE: these data-only registers are qualified by pending and never seen
  // before a capture, so they are deliberately left without a reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (req_trig[i] && !pending[i]) begin
        cap_w_r[i]   <= req_w_r[i];
        cap_dev[i]   <= req_dev_id[i*DEV_W +: DEV_W];
        cap_addr[i]  <= req_addr[i*ADDR_W +: ADDR_W];
        cap_wdata[i] <= req_wdata[i*8 +: 8];
      end
    end
  end

  // One-hot mux of the granted channel's captured fields.
  always_comb begin
    sel_w_r   = 1'b0;
    sel_dev   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_oh[i]) begin
        sel_w_r   = cap_w_r[i];
        sel_dev   = cap_dev[i];
        sel_addr  = cap_addr[i];
        sel_wdata = cap_wdata[i];
      end
    end
  end

  // Pending set/clear, grant register, engine command and byte-done returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending       <= '0;
      grant_oh      <= '0;
      drv_pluse     <= 1'b0;
      drv_w_r       <= 1'b0;
      drv_dev_id    <= '0;
      drv_addr      <= '0;
      drv_wdata     <= '0;
      req_byte_over <= '0;
      req_rdata     <= '0;
    end else begin
      // A trigger on an already-pending channel leaves it unchanged.
      pending   <= (pending | req_trig) & ~rel_mask;
      if (do_grant) grant_oh <= arb_grant;
      drv_pluse <= do_issue;
      if (do_issue) begin
        drv_w_r    <= sel_w_r;
        drv_dev_id <= sel_dev;
        drv_addr   <= sel_addr;
        drv_wdata  <= sel_wdata;
      end
      req_byte_over <= do_byte ? grant_oh : '0;
      if (do_byte) req_rdata <= drv_rdata;
    end
  end

`ifdef I2C_CFG_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TO_CYC + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             waiting;

  assign waiting = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign to_hit  = waiting && (to_cnt == CNT_W'(TO_CYC - 1));

  // Cycles spent waiting on the engine for the current transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              to_cnt <= '0;
    else if (state == ISSUE) to_cnt <= '0;
    else if (waiting)        to_cnt <= to_cnt + 1'b1;
  end

  // One-cycle error pulse to the channel whose transaction timed out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_err <= '0;
    else        req_err <= do_timeout ? grant_oh : '0;
  end
`else
  assign to_hit  = 1'b0;
  assign req_err = '0;
`endif

endmodule

// File: tb/tb_i2c_cfg_arb.sv
// Self-checking bench for i2c_cfg_arb: directed scenarios plus randomized
// traffic, checked against a transaction-level model of pending slots and
// round-robin order. Honours I2C_CFG_ARB_TIMEOUT_EN for the timeout case.
module tb_i2c_cfg_arb;

  localparam int N_CH   = 2;
  localparam int ADDR_W = 16;
  localparam int TO_CYC = 100;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_CH-1:0]        req_trig;
  logic [N_CH-1:0]        req_w_r;
  logic [8*N_CH-1:0]      req_dev_id;
  logic [ADDR_W*N_CH-1:0] req_addr;
  logic [8*N_CH-1:0]      req_wdata;
  logic [N_CH-1:0]        req_busy;
  logic [N_CH-1:0]        req_byte_over;
  logic [7:0]             req_rdata;
  logic [N_CH-1:0]        req_err;
  logic [N_CH-1:0]        grant_oh;

  i2c_cfg_arb_if #(.ADDR_W(ADDR_W)) drv ();

  i2c_cfg_arb #(.N_CH(N_CH), .ADDR_W(ADDR_W), .TO_CYC(TO_CYC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_trig      (req_trig),
    .req_w_r       (req_w_r),
    .req_dev_id    (req_dev_id),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_busy      (req_busy),
    .req_byte_over (req_byte_over),
    .req_rdata     (req_rdata),
    .req_err       (req_err),
    .grant_oh      (grant_oh),
    .drv_pluse     (drv.pluse),
    .drv_w_r       (drv.w_r),
    .drv_dev_id    (drv.dev_id),
    .drv_addr      (drv.addr),
    .drv_wdata     (drv.wdata),
    .drv_busy      (drv.busy),
    .drv_byte_over (drv.byte_over),
    .drv_rdata     (drv.rdata)
  );

  always #5 clk = ~clk;

  // Reference model: pending slot and captured fields per channel, last owner.
  bit          m_pend [N_CH];
  bit          m_wr   [N_CH];
  logic [7:0]  m_dev  [N_CH];
  logic [15:0] m_addr [N_CH];
  logic [7:0]  m_wdat [N_CH];
  int          m_last;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++) m_pend[c] = 1'b0;
    m_last = N_CH - 1;  // next search starts at channel 0
  endfunction

  // A trigger only opens a slot that is empty; it then holds the inputs.
  function automatic void model_trig(input logic [N_CH-1:0] mask);
    for (int c = 0; c < N_CH; c++) begin
      if (mask[c] && !m_pend[c]) begin
        m_pend[c] = 1'b1;
        m_wr[c]   = req_w_r[c];
        m_dev[c]  = req_dev_id[c*8 +: 8];
        m_addr[c] = req_addr[c*ADDR_W +: ADDR_W];
        m_wdat[c] = req_wdata[c*8 +: 8];
      end
    end
  endfunction

  // Next owner: first pending channel after the last owner, wrapping.
  function automatic int rr_next();
    for (int k = 1; k <= N_CH; k++) begin
      if (m_pend[(m_last + k) % N_CH]) return (m_last + k) % N_CH;
    end
    return -1;
  endfunction

  function automatic logic [N_CH-1:0] pend_vec();
    logic [N_CH-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c] = m_pend[c];
    return v;
  endfunction

  task automatic set_fields(input int ch, input bit wr, input logic [7:0] dev,
                            input logic [15:0] a, input logic [7:0] d);
    req_w_r[ch]                 = wr;
    req_dev_id[ch*8 +: 8]       = dev;
    req_addr[ch*ADDR_W +: ADDR_W] = a;
    req_wdata[ch*8 +: 8]        = d;
  endtask

  task automatic rand_fields();
    for (int c = 0; c < N_CH; c++)
      set_fields(c, 1'($urandom), 8'($urandom), 16'($urandom), 8'($urandom));
  endtask

  task automatic trig(input logic [N_CH-1:0] mask);
    req_trig = mask;
    model_trig(mask);
    tick();
    req_trig = '0;
  endtask

  task automatic wait_pluse(output bit ok);
    int n = 0;
    while (!drv.pluse && n < 20) begin
      tick();
      n++;
    end
    ok = drv.pluse;
    if (!ok) check("pluse_wait", 32'(drv.pluse), 32'd1);
  endtask

  // One whole engine transaction for the expected owner. mid_mask triggers
  // during WAIT_DONE, clr_mask triggers on the cycle busy falls.
  task automatic serve(input logic [N_CH-1:0] mid_mask, input logic [N_CH-1:0] clr_mask,
                       input bit do_byte, input logic [7:0] rd);
    int ch;
    bit ok;
    ch = rr_next();
    if (ch < 0) return;
    wait_pluse(ok);
    if (!ok) return;
    check("grant", 32'(grant_oh), 32'(1 << ch));
    check("drv_w_r", 32'(drv.w_r), 32'(m_wr[ch]));
    check("drv_dev_id", 32'(drv.dev_id), 32'(m_dev[ch]));
    check("drv_addr", 32'(drv.addr), 32'(m_addr[ch]));
    check("drv_wdata", 32'(drv.wdata), 32'(m_wdat[ch]));
    drv.busy = 1'b1;
    tick();
    check("pluse_width", 32'(drv.pluse), 32'd0);
    req_trig = mid_mask;
    model_trig(mid_mask);
    tick();
    req_trig = '0;
    if (do_byte) begin
      drv.byte_over = 1'b1;
      drv.rdata     = rd;
      tick();
      drv.byte_over = 1'b0;
      check("byte_over", 32'(req_byte_over), 32'(1 << ch));
      check("rdata", 32'(req_rdata), 32'(rd));
      tick();
      check("byte_over_width", 32'(req_byte_over), 32'd0);
    end
    drv.busy = 1'b0;
    req_trig = clr_mask;
    model_trig(clr_mask);
    m_pend[ch] = 1'b0;
    m_last     = ch;
    tick();
    req_trig = '0;
    check("busy_after", 32'(req_busy), 32'(pend_vec()));
    check("drv_addr_hold", 32'(drv.addr), 32'(m_addr[ch]));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(req_busy), 32'd0);
    check({tag, "_byte_over"}, 32'(req_byte_over), 32'd0);
    check({tag, "_err"}, 32'(req_err), 32'd0);
    check({tag, "_grant"}, 32'(grant_oh), 32'd0);
    check({tag, "_rdata"}, 32'(req_rdata), 32'd0);
    check({tag, "_drv"}, {drv.pluse, drv.w_r, drv.dev_id, drv.wdata, drv.addr[13:0]}, 32'd0);
    check({tag, "_drv_addr"}, 32'(drv.addr), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  ch;
    int  err_at;
    int  err_cycles;
    int  guard;
    bit  ok;
    bit  seen;
    logic [N_CH-1:0] err_val;

    rst_n         = 1'b0;
    req_trig      = '0;
    req_w_r       = '0;
    req_dev_id    = '0;
    req_addr      = '0;
    req_wdata     = '0;
    drv.busy      = 1'b0;
    drv.byte_over = 1'b0;
    drv.rdata     = '0;
    model_reset();
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Write on ch0 with exact trigger-to-pluse latency.
    set_fields(0, 1'b1, 8'hB2, 16'h1234, 8'h5A);
    trig(2'b01);
    check("busy_rise", 32'(req_busy), 32'b01);
    tick();
    check("pluse_lat2", 32'(drv.pluse), 32'd0);
    tick();
    check("pluse_lat3", 32'(drv.pluse), 32'd1);
    serve('0, '0, 1'b0, 8'h00);

    // Read on ch1; only ch1 sees the byte pulse.
    set_fields(1, 1'b0, 8'hA1, 16'h0042, 8'h00);
    trig(2'b10);
    serve('0, '0, 1'b1, 8'hC3);

    // Contention: both channels each round, alternating grants.
    for (int r = 0; r < 4; r++) begin
      rand_fields();
      trig(2'b11);
      serve('0, '0, 1'b1, 8'($urandom));
      serve('0, '0, 1'b0, 8'h00);
      check("contention_drain", 32'(req_busy), 32'd0);
    end

    // Re-trigger while busy is ignored and the first address is kept.
    set_fields(0, 1'b1, 8'h50, 16'h1111, 8'h77);
    trig(2'b01);
    set_fields(0, 1'b1, 8'h50, 16'h9999, 8'h77);
    serve(2'b01, '0, 1'b0, 8'h00);
    check("retrig_addr", 32'(drv.addr), 32'h1111);
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen |= drv.pluse;
    end
    check("retrig_no_extra", 32'(seen), 32'd0);

    // Trigger of the owner on its own clearing cycle is dropped.
    rand_fields();
    trig(2'b10);
    serve('0, 2'b10, 1'b0, 8'h00);
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen |= drv.pluse;
    end
    check("clr_trig_no_pluse", 32'(seen), 32'd0);
    check("clr_trig_busy", 32'(req_busy), 32'd0);

    // Randomized traffic with queued triggers during transactions.
    for (int it = 0; it < 12; it++) begin
      rand_fields();
      trig(2'($urandom_range(1, 3)));
      guard = 0;
      while (rr_next() >= 0 && guard < 8) begin
        rand_fields();
        serve(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 8'($urandom));
        guard++;
      end
    end
    guard = 0;
    while (rr_next() >= 0 && guard < 8) begin
      serve('0, '0, 1'b0, 8'h00);
      guard++;
    end
    check("random_drain", 32'(req_busy), 32'(pend_vec()));

    // Engine stuck busy.
    rand_fields();
    trig(2'b11);
    ch = rr_next();
    wait_pluse(ok);
    check("to_grant", 32'(grant_oh), 32'(1 << ch));
    drv.busy   = 1'b1;
    err_at     = -1;
    err_cycles = 0;
    err_val    = '0;
    for (int n = 1; n <= 150; n++) begin
      tick();
      if (req_err != '0) begin
        err_cycles++;
        if (err_at < 0) begin
          err_at  = n;
          err_val = req_err;
        end
      end
    end
`ifdef I2C_CFG_ARB_TIMEOUT_EN
    check("to_err_cycle", 32'(err_at), 32'(TO_CYC));
    check("to_err_chan", 32'(err_val), 32'(1 << ch));
    check("to_err_width", 32'(err_cycles), 32'd1);
    m_pend[ch] = 1'b0;
    m_last     = ch;
    check("to_busy_clear", 32'(req_busy), 32'(pend_vec()));
    drv.busy = 1'b0;
    tick();
`else
    check("no_to_err", 32'(err_cycles), 32'd0);
    check("no_to_still_busy", 32'(req_busy[ch]), 32'd1);
    drv.busy = 1'b0;
    tick();
    m_pend[ch] = 1'b0;
    m_last     = ch;
    check("no_to_done", 32'(req_busy), 32'(pend_vec()));
`endif
    guard = 0;
    while (rr_next() >= 0 && guard < 4) begin
      serve('0, '0, 1'b0, 8'h00);
      guard++;
    end

    // Reset in WAIT_DONE while the engine reports a byte.
    rand_fields();
    trig(2'b01);
    wait_pluse(ok);
    drv.busy = 1'b1;
    tick();
    tick();
    drv.byte_over = 1'b1;
    drv.rdata     = 8'hEE;
    rst_n         = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    check("midrst_byte", 32'(req_byte_over), 32'd0);
    check("midrst_err", 32'(req_err), 32'd0);
    drv.byte_over = 1'b0;
    drv.busy      = 1'b0;
    rst_n         = 1'b1;
    model_reset();
    seen = 1'b0;
    repeat (5) begin
      tick();
      seen |= (|req_byte_over) | (|req_err) | drv.pluse | (|req_busy);
    end
    check("postrst_quiet", 32'(seen), 32'd0);

    // Priority restarts at channel 0 after reset.
    rand_fields();
    trig(2'b11);
    serve('0, '0, 1'b0, 8'h00);
    serve('0, '0, 1'b1, 8'h3C);
    check("final_idle", 32'(req_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
